pdm_decimator: RTL

Consumes the 16-bit PDM words produced by the microphone deserializer and turns them into signed PCM samples. Each accepted word is reduced to its ones-count. `WORDS_PER_SAMPLE` counts are summed, centred around zero, scaled and saturated. Samples are presented on a valid/ready port to the downstream audio buffer.

---
 rtl/pdm_pkg.sv | 33 +++
 rtl/pdm_dc_block.sv | 62 ++++++
 rtl/pdm_decimator.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM-to-PCM decimator: word width, FSM state
// type, DC-blocker constants and the popcount/saturation helpers.
package pdm_pkg;

  localparam int WORD_W   = 16;
  localparam int DC_SHIFT = 8;
  localparam int DC_W     = 24;

  typedef enum logic {IDLE, ACCUM} decim_state_t;

  // Number of ones in a 16-bit PDM word (0..16).
  function automatic logic [4:0] popcount16(input logic [WORD_W-1:0] w);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) begin
      c = c + {4'b0000, w[i]};
    end
    return c;
  endfunction

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pdm_dc_block.sv
// First-order DC blocker: y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> DC_SHIFT).
// Filter state is DC_W-bit signed; the output is saturated to OUT_W.
// One cycle of latency from in_valid to out_valid.
module pdm_dc_block
  import pdm_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [OUT_W-1:0] in_sample,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_sample
);

  logic signed [DC_W-1:0]  x_prev_q, x_prev_d;
  logic signed [DC_W-1:0]  y_prev_q, y_prev_d;
  logic                    out_vld_q, out_vld_d;
  logic signed [OUT_W-1:0] out_q, out_d;
  logic signed [63:0]      y_full;

  // Filter arithmetic at full width; state and output saturate separately.
  always_comb begin
    y_full    = 64'(in_sample) - 64'(x_prev_q) + 64'(y_prev_q)
              - (64'(y_prev_q) >>> DC_SHIFT);
    x_prev_d  = x_prev_q;
    y_prev_d  = y_prev_q;
    out_d     = out_q;
    out_vld_d = 1'b0;
    if (clear) begin
      x_prev_d = '0;
      y_prev_d = '0;
      out_d    = '0;
    end else if (in_valid) begin
      x_prev_d  = DC_W'(in_sample);
      y_prev_d  = DC_W'(saturate(y_full, DC_W));
      out_d     = OUT_W'(saturate(y_full, OUT_W));
      out_vld_d = 1'b1;
    end
  end

  // Filter state and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_q  <= '0;
      y_prev_q  <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      x_prev_q  <= x_prev_d;
      y_prev_q  <= y_prev_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_valid  = out_vld_q;
  assign out_sample = out_q;

endmodule

// File: rtl/pdm_decimator.sv
// PDM word decimator: rising-edge word acceptance, popcount, accumulation of
// WORDS_PER_SAMPLE counts, centring, gain shift, saturation and a one-entry
// valid/ready output register with a sticky overrun flag.
// Optional DC blocker enabled by defining PDM_DECIM_DC_BLOCK_EN (adds one
// cycle of latency).
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int WORDS_PER_SAMPLE = 4,
  parameter int GAIN_SHIFT       = 8,
  parameter int OUT_W            = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic [OUT_W-1:0]  sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  localparam int ACC_W  = $clog2(WORDS_PER_SAMPLE * WORD_W + 1);
  localparam int CNT_W  = $clog2(WORDS_PER_SAMPLE);
  localparam int CENTRE = WORDS_PER_SAMPLE * (WORD_W / 2);

  decim_state_t       state_q, state_d;
  logic               wv_prev_q, wv_prev_d;
  logic [4:0]         pop_q, pop_d;
  logic               pop_vld_q, pop_vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   comp_q, comp_d;
  logic               comp_vld_q, comp_vld_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_vld_q, out_vld_d;
  logic               overrun_q, overrun_d;

  logic               accept;
  logic [ACC_W-1:0]   sum;
  logic signed [63:0] centred;
  logic signed [63:0] scaled;
  logic               new_vld;
  logic [OUT_W-1:0]   new_sample;

  // Front end: FSM, edge detection and registered popcount of accepted words.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    accept    = enable & word_valid & ~wv_prev_q;
    state_d   = enable ? ACCUM : IDLE;
    wv_prev_d = enable ? word_valid : 1'b0;
    pop_d     = popcount16(word_in);
    pop_vld_d = accept;
  end

  // Accumulator, word counter and sample completion (centre, scale, clamp).
  always_comb begin
    sum        = acc_q + ACC_W'(pop_q);
    centred    = $signed(64'(sum)) - 64'(CENTRE);
    scaled     = centred <<< GAIN_SHIFT;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    comp_d     = comp_q;
    comp_vld_d = 1'b0;
    if (state_q == IDLE || !enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (pop_vld_q) begin
      if (cnt_q == CNT_W'(WORDS_PER_SAMPLE - 1)) begin
        acc_d      = '0;
        cnt_d      = '0;
        comp_d     = OUT_W'(saturate(scaled, OUT_W));
        comp_vld_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef PDM_DECIM_DC_BLOCK_EN
  pdm_dc_block #(
    .OUT_W(OUT_W)
  ) u_dc_block (
    .clk       (clock),
    .rst_n     (reset_n),
    .clear     (state_q == IDLE),
    .in_valid  (comp_vld_q),
    .in_sample (comp_q),
    .out_valid (new_vld),
    .out_sample(new_sample)
  );
`else
  assign new_vld    = comp_vld_q;
  assign new_sample = comp_q;
`endif

  // Output register: load when empty or draining, otherwise drop and flag.
  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    overrun_d = overrun_q;
    if (new_vld && (!out_vld_q || sample_ready)) begin
      out_d     = new_sample;
      out_vld_d = 1'b1;
    end else if (out_vld_q && sample_ready) begin
      out_vld_d = 1'b0;
    end
    if (new_vld && out_vld_q && !sample_ready) begin
      overrun_d = 1'b1;
    end
  end

  // All pipeline state.
  // NOTE: sequential state is updated with non-blocking '<=' only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wv_prev_q  <= 1'b0;
      pop_q      <= '0;
      pop_vld_q  <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      comp_q     <= '0;
      comp_vld_q <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wv_prev_q  <= wv_prev_d;
      pop_q      <= pop_d;
      pop_vld_q  <= pop_vld_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      comp_q     <= comp_d;
      comp_vld_q <= comp_vld_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = out_vld_q;
  assign overrun      = overrun_q;

endmodule
